// File: rtl/qoa_pkg.sv
// Shared definitions for the QOA sample SPI transmitter.
// The optional MISO capture path is enabled with the macro QOA_SPI_RX_EN.
package qoa_pkg;

    // Default sample / frame width.
    localparam int QOA_SAMPLE_W = 16;

    // Width of the sclk half-period divider (CLK_DIV up to 255).
    localparam int DIV_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        GAP
    } spi_tx_state_t;

    // Observation bundle for bound checkers: FSM state plus the pins it drives.
    typedef struct packed {
        spi_tx_state_t state;
        logic          tick;
        logic          sclk;
        logic          cs_n;
        logic          mosi;
    } spi_tx_dbg_t;

endpackage

// File: rtl/qoa_sample_fifo.sv
// Synchronous show-ahead FIFO: dout always presents the head entry.
// Pushes while full and pops while empty are ignored.
module qoa_sample_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push;
    logic          do_pop;

    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign dout  = mem[rd_ptr_q];

    // Pointer and occupancy update; a simultaneous push and pop keeps the count.
    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents need no reset because the count gates reads.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/qoa_spi_sample_tx.sv
// SPI mode 0 initiator streaming PCM samples MSB first from a small FIFO.
// Frame: cs_n falls, SAMPLE_W sclk pulses of CLK_DIV-cycle half periods,
// one half period of hold, cs_n high for one half period, then the next
// frame may start. Macro QOA_SPI_RX_EN adds capture of miso into rx_word.
//
// Handshake: a sample is accepted on any clk edge with sample_valid high and
// sample_ready high; sample_valid while sample_ready is low drops the sample
// and sets the sticky overflow flag.
module qoa_spi_sample_tx
    import qoa_pkg::*;
#(
    parameter int CLK_DIV    = 2,
    parameter int SAMPLE_W   = QOA_SAMPLE_W,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [SAMPLE_W-1:0] sample_in,
    input  logic                sample_valid,
    output logic                sample_ready,
    output logic                sclk,
    output logic                mosi,
    output logic                cs_n,
    input  logic                miso,
    output logic                busy,
    output logic                overflow,
    output logic [SAMPLE_W-1:0] rx_word,
    output logic                rx_valid
);

    localparam int                BIT_W    = (SAMPLE_W > 2) ? $clog2(SAMPLE_W) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST = BIT_W'(SAMPLE_W - 1);

    logic [1:0]          rst_sync_q;
    logic                rst_int_n;

    spi_tx_state_t       state_q, state_d;
    logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
    logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [SAMPLE_W-1:0] shreg_q, shreg_d;
    logic                sclk_q, sclk_d;
    logic                cs_n_q, cs_n_d;
    logic                mosi_q, mosi_d;
    logic                overflow_q, overflow_d;

    logic                tick;
    logic                launch;
    logic                fifo_pop;
    logic                fifo_full;
    logic                fifo_empty;
    logic [SAMPLE_W-1:0] fifo_dout;

    // Observation point for checkers; not consumed by the logic.
    spi_tx_dbg_t         unused_fsm_dbg;

    // Reset asserts asynchronously and releases two clk edges after rst_n rises.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_int_n = rst_sync_q[1];

    qoa_sample_fifo #(
        .W     (SAMPLE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_int_n),
        .push  (sample_valid),
        .pop   (fifo_pop),
        .din   (sample_in),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign tick = (div_cnt_q == DIV_LAST);

    // Frame sequencing: next state, pin values and divider restart.
    always_comb begin
        state_d   = state_q;
        sclk_d    = sclk_q;
        cs_n_d    = cs_n_q;
        mosi_d    = mosi_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        launch    = 1'b0;
        fifo_pop  = 1'b0;

        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    launch = 1'b1;
                end
            end
            SETUP: begin
                if (tick) begin
                    sclk_d  = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (tick) begin
                    if (sclk_q) begin
                        sclk_d    = 1'b0;
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        if (bit_cnt_q == BIT_LAST) begin
                            state_d = HOLD;
                        end else begin
                            // Data changes on the falling edge.
                            mosi_d  = shreg_q[SAMPLE_W-2];
                            shreg_d = {shreg_q[SAMPLE_W-2:0], 1'b0};
                        end
                    end else begin
                        sclk_d = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (tick) begin
                    cs_n_d  = 1'b1;
                    mosi_d  = 1'b0;
                    state_d = GAP;
                end
            end
            GAP: begin
                if (tick) begin
                    state_d = IDLE;
                    // The edge that re-enters IDLE may already start the next frame.
                    if (!fifo_empty) begin
                        launch = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (launch) begin
            fifo_pop  = 1'b1;
            shreg_d   = fifo_dout;
            cs_n_d    = 1'b0;
            mosi_d    = fifo_dout[SAMPLE_W-1];
            bit_cnt_d = '0;
            state_d   = SETUP;
        end

        div_cnt_d  = (tick || (state_d != state_q)) ? '0 : div_cnt_q + 1'b1;
        overflow_d = overflow_q | (sample_valid & fifo_full);
    end

    // FSM, divider, shift register and registered SPI pins.
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_q    <= IDLE;
            div_cnt_q  <= '0;
            bit_cnt_q  <= '0;
            shreg_q    <= '0;
            sclk_q     <= 1'b0;
            cs_n_q     <= 1'b1;
            mosi_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_cnt_q  <= div_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shreg_q    <= shreg_d;
            sclk_q     <= sclk_d;
            cs_n_q     <= cs_n_d;
            mosi_q     <= mosi_d;
            overflow_q <= overflow_d;
        end
    end

`ifdef QOA_SPI_RX_EN
    logic                rise_now;
    logic [SAMPLE_W-1:0] rx_shreg_q, rx_shreg_d;
    logic [SAMPLE_W-1:0] rx_word_q, rx_word_d;
    logic                rx_valid_q, rx_valid_d;

    // miso is sampled on every edge that raises sclk; the word is published as cs_n rises.
    always_comb begin
        rise_now   = tick && ((state_q == SETUP) || ((state_q == SHIFT) && !sclk_q));
        rx_shreg_d = rx_shreg_q;
        rx_word_d  = rx_word_q;
        rx_valid_d = 1'b0;
        if (rise_now) begin
            rx_shreg_d = {rx_shreg_q[SAMPLE_W-2:0], miso};
        end
        if (tick && (state_q == HOLD)) begin
            rx_word_d  = rx_shreg_q;
            rx_valid_d = 1'b1;
        end
    end

    // Receive capture registers.
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            rx_shreg_q <= '0;
            rx_word_q  <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            rx_shreg_q <= rx_shreg_d;
            rx_word_q  <= rx_word_d;
            rx_valid_q <= rx_valid_d;
        end
    end

    assign rx_word  = rx_word_q;
    assign rx_valid = rx_valid_q;
`else
    logic unused_miso;

    assign unused_miso = miso;
    assign rx_word     = '0;
    assign rx_valid    = 1'b0;
`endif

    assign sclk         = sclk_q;
    assign mosi         = mosi_q;
    assign cs_n         = cs_n_q;
    assign overflow     = overflow_q;
    assign sample_ready = !fifo_full;
    assign busy         = (state_q != IDLE) || !fifo_empty;

    assign unused_fsm_dbg = '{state: state_q, tick: tick, sclk: sclk_q,
                              cs_n: cs_n_q, mosi: mosi_q};

endmodule

// File: tb/tb_qoa_spi_sample_tx.sv
// Bench for qoa_spi_sample_tx: one instance with CLK_DIV=2 (with a MISO target
// model returning 0xBEEF) and one with CLK_DIV=1. Build with QOA_SPI_RX_EN
// defined to exercise the receive path.
module tb_qoa_spi_sample_tx;

    localparam int DEPTH = 4;
`ifdef QOA_SPI_RX_EN
    localparam bit RXEN = 1'b1;
`else
    localparam bit RXEN = 1'b0;
`endif

    typedef struct {
        logic [15:0] word;
        int          low;
        int          rises;
        int          falls;
        int          gap;
        int          start;
        bit          ok_phase;
        bit          ok_setup;
        bit          rxv_low;
        logic        rxv_rise;
        logic [15:0] rx_word;
        logic        end_sclk;
        logic        end_mosi;
        bit          timeout;
    } frame_t;

    typedef struct {
        int          d;
        logic [15:0] data;
        logic [15:0] exp_word;
        int          exp_low;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] din0 = '0, din1 = '0;
    logic        sv0 = 1'b0, sv1 = 1'b0;
    logic        rdy0, rdy1, sclk0, sclk1, mosi0, mosi1, cs_n0, cs_n1;
    logic        busy0, busy1, ovf0, ovf1, rxv0, rxv1;
    logic [15:0] rxw0, rxw1;
    logic        miso0;
    logic        miso1 = 1'b0;

    logic [15:0] tgt_word = 16'hBEEF;
    logic [4:0]  tgt_cnt = 5'd0;

    int          cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;
    logic [15:0] stim_q[$];
    logic [15:0] exp_q[$];
    bit          exp_ovf[2];

    // ---------------- clock / reset block ----------------
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // SPI target model: presents the next bit of tgt_word before each rising sclk.
    always @(posedge sclk0 or posedge cs_n0) begin
        if (cs_n0) tgt_cnt <= 5'd0;
        else       tgt_cnt <= tgt_cnt + 5'd1;
    end

    always_comb begin
        miso0 = 1'b0;
        if (tgt_cnt < 5'd16) miso0 = tgt_word[4'(5'd15 - tgt_cnt)];
    end

    qoa_spi_sample_tx #(.CLK_DIV(2), .SAMPLE_W(16), .FIFO_DEPTH(DEPTH)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .sample_in(din0), .sample_valid(sv0),
        .sample_ready(rdy0), .sclk(sclk0), .mosi(mosi0), .cs_n(cs_n0),
        .miso(miso0), .busy(busy0), .overflow(ovf0), .rx_word(rxw0), .rx_valid(rxv0)
    );

    qoa_spi_sample_tx #(.CLK_DIV(1), .SAMPLE_W(16), .FIFO_DEPTH(DEPTH)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .sample_in(din1), .sample_valid(sv1),
        .sample_ready(rdy1), .sclk(sclk1), .mosi(mosi1), .cs_n(cs_n1),
        .miso(miso1), .busy(busy1), .overflow(ovf1), .rx_word(rxw1), .rx_valid(rxv1)
    );

    function automatic logic get_cs(input int d);   return (d == 0) ? cs_n0 : cs_n1; endfunction
    function automatic logic get_sclk(input int d); return (d == 0) ? sclk0 : sclk1; endfunction
    function automatic logic get_mosi(input int d); return (d == 0) ? mosi0 : mosi1; endfunction
    function automatic logic get_busy(input int d); return (d == 0) ? busy0 : busy1; endfunction
    function automatic logic get_ovf(input int d);  return (d == 0) ? ovf0 : ovf1; endfunction
    function automatic logic get_rdy(input int d);  return (d == 0) ? rdy0 : rdy1; endfunction
    function automatic logic get_rxv(input int d);  return (d == 0) ? rxv0 : rxv1; endfunction
    function automatic logic [15:0] get_rxw(input int d); return (d == 0) ? rxw0 : rxw1; endfunction
    function automatic int cd_of(input int d); return (d == 0) ? 2 : 1; endfunction

    // ---------------- scoreboard compare ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic push_burst(input int d);
        foreach (stim_q[i]) begin
            if (d == 0) begin sv0 = 1'b1; din0 = stim_q[i]; end
            else        begin sv1 = 1'b1; din1 = stim_q[i]; end
            @(negedge clk);
        end
        sv0 = 1'b0;
        sv1 = 1'b0;
    endtask

    // Observe one frame at negedges: high time before it, bits at rising sclk,
    // phase widths, mosi setup and the receive strobe.
    task automatic capture_frame(input int d, output frame_t f);
        int   guard;
        int   run;
        int   m_age;
        int   cd;
        logic s, m, prev_s, prev_m;
        cd = cd_of(d);
        f.word = '0; f.low = 0; f.rises = 0; f.falls = 0; f.gap = 0; f.start = 0;
        f.ok_phase = 1'b1; f.ok_setup = 1'b1; f.rxv_low = 1'b0; f.rxv_rise = 1'b0;
        f.rx_word = '0; f.end_sclk = 1'b0; f.end_mosi = 1'b0; f.timeout = 1'b0;
        guard = 0;
        while (get_cs(d) == 1'b1) begin
            if (guard >= 4000) begin f.timeout = 1'b1; return; end
            guard++;
            @(negedge clk);
        end
        f.gap = guard;
        f.start = cyc;
        prev_s = 1'b0; prev_m = 1'b0; run = 0; m_age = 0;
        while (get_cs(d) == 1'b0) begin
            s = get_sclk(d);
            m = get_mosi(d);
            if (f.low == 0 || m != prev_m) m_age = 0;
            else m_age++;
            if (s != prev_s) begin
                if (run != cd) f.ok_phase = 1'b0;
                run = 0;
            end
            if (s && !prev_s) begin
                f.rises++;
                f.word = {f.word[14:0], m};
                if (m_age < cd) f.ok_setup = 1'b0;
            end
            if (!s && prev_s) f.falls++;
            if (get_rxv(d)) f.rxv_low = 1'b1;
            run++;
            f.low++;
            prev_s = s;
            prev_m = m;
            if (f.low > 4000) begin f.timeout = 1'b1; return; end
            @(negedge clk);
        end
        if (run != cd) f.ok_phase = 1'b0;
        f.rxv_rise = get_rxv(d);
        f.rx_word  = get_rxw(d);
        f.end_sclk = get_sclk(d);
        f.end_mosi = get_mosi(d);
    endtask

    task automatic check_frame(input int d, input frame_t f, input logic [15:0] exp_word,
                               input int exp_low, input string tag);
        logic [15:0] exp_rx;
        exp_rx = (RXEN && d == 0) ? 16'hBEEF : 16'h0000;
        chk({tag, "_timeout"}, 32'(f.timeout), 0);
        chk({tag, "_word"}, 32'(f.word), 32'(exp_word));
        chk({tag, "_cs_low"}, f.low, exp_low);
        chk({tag, "_rises"}, f.rises, 16);
        chk({tag, "_falls"}, f.falls, 16);
        chk({tag, "_phase"}, 32'(f.ok_phase), 1);
        chk({tag, "_setup"}, 32'(f.ok_setup), 1);
        chk({tag, "_end_sclk"}, 32'(f.end_sclk), 0);
        chk({tag, "_end_mosi"}, 32'(f.end_mosi), 0);
        chk({tag, "_rxv_early"}, 32'(f.rxv_low), 0);
        chk({tag, "_rxv_at_cs"}, 32'(f.rxv_rise), 32'(RXEN));
        chk({tag, "_rx_word"}, 32'(f.rx_word), 32'(exp_rx));
    endtask

    // Reference model: a burst of n back-to-back pushes into an idle block has
    // exactly one pop inside it (a frame lasts 34*CLK_DIV >= 34 cycles), so the
    // first DEPTH+1 samples are sent in order and the rest are dropped.
    task automatic run_burst(input int d, input string tag);
        int     cd;
        int     n_acc;
        int     prev_start;
        int     quiet;
        frame_t f;
        cd = cd_of(d);
        n_acc = (stim_q.size() > DEPTH + 1) ? DEPTH + 1 : stim_q.size();
        exp_q.delete();
        for (int i = 0; i < n_acc; i++) exp_q.push_back(stim_q[i]);
        if (stim_q.size() > DEPTH + 1) exp_ovf[d] = 1'b1;
        prev_start = 0;
        fork
            push_burst(d);
            begin
                for (int k = 0; k < n_acc; k++) begin
                    capture_frame(d, f);
                    check_frame(d, f, exp_q.pop_front(), 33 * cd, tag);
                    if (k > 0) begin
                        chk({tag, "_cs_high"}, f.gap, cd);
                        chk({tag, "_period"}, f.start - prev_start, 34 * cd);
                    end
                    prev_start = f.start;
                end
            end
        join
        quiet = 0;
        for (int i = 0; i < 40 * cd + 4; i++) begin
            @(negedge clk);
            if (get_cs(d) == 1'b0) quiet++;
        end
        chk({tag, "_no_extra_frame"}, quiet, 0);
        chk({tag, "_overflow"}, 32'(get_ovf(d)), 32'(exp_ovf[d]));
        chk({tag, "_busy_done"}, 32'(get_busy(d)), 0);
    endtask

    // ---------------- main test ----------------
    initial begin
        vec_t   vecs[5];
        frame_t f;
        int     rises;
        int     guard;
        int     quiet;
        logic   prev;

        exp_ovf[0] = 1'b0;
        exp_ovf[1] = 1'b0;
        vecs[0] = '{0, 16'hA5C3, 16'hA5C3, 66};
        vecs[1] = '{0, 16'h0001, 16'h0001, 66};
        vecs[2] = '{1, 16'h1234, 16'h1234, 33};
        vecs[3] = '{1, 16'hFFFF, 16'hFFFF, 33};
        vecs[4] = '{0, 16'h8000, 16'h8000, 66};

        // Reset values, checked while rst_n is held low.
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("rst_cs_n", 32'(get_cs(d)), 1);
            chk("rst_sclk", 32'(get_sclk(d)), 0);
            chk("rst_mosi", 32'(get_mosi(d)), 0);
            chk("rst_ready", 32'(get_rdy(d)), 1);
            chk("rst_busy", 32'(get_busy(d)), 0);
            chk("rst_overflow", 32'(get_ovf(d)), 0);
            chk("rst_rx_word", 32'(get_rxw(d)), 0);
            chk("rst_rx_valid", 32'(get_rxv(d)), 0);
        end
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Table of single-sample frames.
        for (int i = 0; i < 5; i++) begin
            stim_q.delete();
            stim_q.push_back(vecs[i].data);
            push_burst(vecs[i].d);
            chk("tbl_ready_after_push", 32'(get_rdy(vecs[i].d)), 1);
            chk("tbl_busy_after_push", 32'(get_busy(vecs[i].d)), 1);
            capture_frame(vecs[i].d, f);
            check_frame(vecs[i].d, f, vecs[i].exp_word, vecs[i].exp_low, $sformatf("tbl%0d", i));
            repeat (cd_of(vecs[i].d) + 1) @(negedge clk);
            chk("tbl_busy_idle", 32'(get_busy(vecs[i].d)), 0);
        end

        // Three back-to-back samples.
        stim_q = '{16'h0001, 16'h8000, 16'hFFFF};
        run_burst(0, "b2b");

        // Randomized bursts against the reference model.
        for (int r = 0; r < 6; r++) begin
            int d;
            int n;
            d = $urandom_range(0, 1);
            n = $urandom_range(1, 7);
            stim_q.delete();
            for (int i = 0; i < n; i++) stim_q.push_back(16'($urandom_range(0, 16'hFFFF)));
            run_burst(d, $sformatf("rnd%0d", r));
        end

        // Six back-to-back samples: one is dropped, overflow stays set.
        stim_q.delete();
        for (int i = 0; i < 6; i++) stim_q.push_back(16'($urandom_range(0, 16'hFFFF)));
        run_burst(0, "ovf");

        // Reset at the fifth rising sclk with samples still queued.
        stim_q = '{16'hC0DE, 16'h1111, 16'h2222};
        rises = 0;
        guard = 0;
        prev = 1'b0;
        fork
            push_burst(0);
            begin
                while (rises < 5 && guard < 1000) begin
                    @(negedge clk);
                    guard++;
                    if (!cs_n0 && sclk0 && !prev) rises++;
                    prev = sclk0;
                end
            end
        join
        chk("midrst_reached_rise5", rises, 5);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_cs_n", 32'(cs_n0), 1);
        chk("midrst_sclk", 32'(sclk0), 0);
        chk("midrst_mosi", 32'(mosi0), 0);
        chk("midrst_busy", 32'(busy0), 0);
        chk("midrst_ready", 32'(rdy0), 1);
        chk("midrst_overflow", 32'(ovf0), 0);
        exp_ovf[0] = 1'b0;
        exp_ovf[1] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        quiet = 0;
        for (int i = 0; i < 3 * 34 * 2; i++) begin
            @(negedge clk);
            if (!cs_n0) quiet++;
        end
        chk("midrst_no_residual_frame", quiet, 0);
        chk("midrst_busy_after", 32'(busy0), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
